// File: rtl/axi3_rd_arbiter_pkg.sv
// Shared types and constants for the AXI3 read-port arbiter.
package axi3_rd_arbiter_pkg;

  // Arbiter FSM encoding, kept as plain constants for legacy tools.
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 1'b0;
  localparam arb_state_t ARB_ISSUE = 1'b1;

  // AR request fields captured from the winning master.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi3_rd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module axi3_rd_arbiter_rr #(
  parameter int unsigned N     = 3,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at ptr and keep the first one asserted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi3_rd_arbiter.sv
// Shares one AXI3 read port among N read masters. AR is arbitrated round-robin
// with ARID carrying the master index; R beats are routed back by RID.
module axi3_rd_arbiter
  import axi3_rd_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 3,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  // Master-facing AR
  input  logic [N_MASTERS-1:0][31:0]           s_araddr,
  input  logic [N_MASTERS-1:0][3:0]            s_arlen,
  input  logic [N_MASTERS-1:0][2:0]            s_arsize,
  input  logic [N_MASTERS-1:0][1:0]            s_arburst,
  input  logic [N_MASTERS-1:0]                 s_arvalid,
  output logic [N_MASTERS-1:0]                 s_arready,
  // Master-facing R
  output logic [N_MASTERS-1:0][DATA_WIDTH-1:0] s_rdata,
  output logic [N_MASTERS-1:0][1:0]            s_rresp,
  output logic [N_MASTERS-1:0]                 s_rlast,
  output logic [N_MASTERS-1:0]                 s_rvalid,
  input  logic [N_MASTERS-1:0]                 s_rready,
  // Interconnect-facing AR
  output logic [31:0]                          m_araddr,
  output logic [3:0]                           m_arlen,
  output logic [2:0]                           m_arsize,
  output logic [1:0]                           m_arburst,
  output logic [ID_WIDTH-1:0]                  m_arid,
  output logic                                 m_arvalid,
  input  logic                                 m_arready,
  // Interconnect-facing R
  input  logic [DATA_WIDTH-1:0]                m_rdata,
  input  logic [1:0]                           m_rresp,
  input  logic                                 m_rlast,
  input  logic [ID_WIDTH-1:0]                  m_rid,
  input  logic                                 m_rvalid,
  output logic                                 m_rready,
  output logic                                 err_rid
);

  localparam int unsigned IDX_W = $clog2(N_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  arb_state_t                      state_q, state_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [IDX_W-1:0]                win_q, win_d;
  ar_req_t                         ar_q, ar_d;
  logic [ID_WIDTH-1:0]             arid_q, arid_d;
  logic [N_MASTERS-1:0][CNT_W-1:0] outst_q, outst_d;
  logic                            err_q;

  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 ar_hs;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_mapped;
  logic                 r_done;
  logic [N_MASTERS-1:0] inc_vec, dec_vec;
  logic                 unused_rid_hi;

  // A master with a full outstanding budget is skipped, not blocked.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      eligible[i] = s_arvalid[i] && (outst_q[i] != CNT_MAX);
    end
  end

  axi3_rd_arbiter_rr #(
    .N (N_MASTERS)
  ) u_rr (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // AR FSM: accept from the winner in IDLE, present it downstream in ISSUE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    ar_d      = ar_q;
    arid_d    = arid_q;
    s_arready = '0;
    ar_hs     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // rst_n gate keeps s_arready low while reset is held.
        if (rst_n && (|eligible)) begin
          s_arready = grant;
          win_d     = grant_idx;
          ar_d      = '{addr:  s_araddr[grant_idx],
                        len:   s_arlen[grant_idx],
                        size:  s_arsize[grant_idx],
                        burst: s_arburst[grant_idx]};
          arid_d    = ID_WIDTH'(grant_idx);
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (m_arready) begin
          ar_hs   = 1'b1;
          ptr_d   = (win_q == IDX_W'(N_MASTERS - 1)) ? '0 : win_q + 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // R routing: purely combinational, unmapped IDs are sunk.
  always_comb begin
    r_idx    = m_rid[IDX_W-1:0];
    r_mapped = (32'(r_idx) < N_MASTERS);
    s_rvalid = '0;
    m_rready = 1'b1;
    if (r_mapped) begin
      s_rvalid[r_idx] = m_rvalid;
      m_rready        = s_rready[r_idx];
    end
    r_done = m_rvalid && m_rready && m_rlast && r_mapped;
  end

  assign s_rdata       = {N_MASTERS{m_rdata}};
  assign s_rresp       = {N_MASTERS{m_rresp}};
  assign s_rlast       = {N_MASTERS{m_rlast}};
  assign unused_rid_hi = ^m_rid[ID_WIDTH-1:IDX_W];

  // Outstanding counters: simultaneous issue and completion cancel out.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    outst_d = outst_q;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      inc_vec[i] = ar_hs && (win_q == IDX_W'(i));
      dec_vec[i] = r_done && (r_idx == IDX_W'(i));
      if (inc_vec[i] && !dec_vec[i]) begin
        outst_d[i] = outst_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        outst_d[i] = outst_q[i] - 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      ar_q    <= '0;
      arid_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      ar_q    <= ar_d;
      arid_q  <= arid_d;
      outst_q <= outst_d;
      if (m_rvalid && !r_mapped) begin
        err_q <= 1'b1;
      end
    end
  end

  assign m_arvalid = (state_q == ARB_ISSUE);
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;
  assign m_arid    = arid_q;
  assign err_rid   = err_q;

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Bench for axi3_rd_arbiter: a negedge monitor models arbitration, counters and
// R routing; accepted AR requests are queued and matched against the m_ar side.
module tb_axi3_rd_arbiter;

  localparam int N  = 3;
  localparam int IW = 4;
  localparam int MO = 2;
  localparam int DW = 32;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0][31:0]   s_araddr;
  logic [N-1:0][3:0]    s_arlen;
  logic [N-1:0][2:0]    s_arsize;
  logic [N-1:0][1:0]    s_arburst;
  logic [N-1:0]         s_arvalid;
  logic [N-1:0]         s_arready;
  logic [N-1:0][DW-1:0] s_rdata;
  logic [N-1:0][1:0]    s_rresp;
  logic [N-1:0]         s_rlast;
  logic [N-1:0]         s_rvalid;
  logic [N-1:0]         s_rready;
  logic [31:0]          m_araddr;
  logic [3:0]           m_arlen;
  logic [2:0]           m_arsize;
  logic [1:0]           m_arburst;
  logic [IW-1:0]        m_arid;
  logic                 m_arvalid;
  logic                 m_arready;
  logic [DW-1:0]        m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic [IW-1:0]        m_rid;
  logic                 m_rvalid;
  logic                 m_rready;
  logic                 err_rid;

  axi3_rd_arbiter #(
    .N_MASTERS  (N),
    .ID_WIDTH   (IW),
    .MAX_OUTST  (MO),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arid    (m_arid),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rid     (m_rid),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .err_rid   (err_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Reference model state
  int          mstate;
  int          mptr;
  int          mwin;
  int          mout [N];
  bit          merr;
  logic [44:0] ar_q[$];
  int          grant_log[$];

  // Monitor: inputs are stable here, so the model advances for the next posedge.
  always @(negedge clk) begin : monitor
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic         exp_mr;
    logic [44:0]  cur;
    int           w;
    int           ridx;
    if (!rst_n) begin
      mstate = 0;
      mptr   = 0;
      mwin   = 0;
      merr   = 1'b0;
      for (int i = 0; i < N; i++) mout[i] = 0;
      ar_q.delete();
      grant_log.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        elig[i] = s_arvalid[i] && (mout[i] != MO);
        check($sformatf("outst%0d", i), 64'(dut.outst_q[i]), 64'(mout[i]));
      end
      exp_rdy = '0;
      w       = -1;
      if (mstate == 0) begin
        w = rr_pick(elig, mptr);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check("s_arready", 64'(s_arready), 64'(exp_rdy));
      check("m_arvalid", 64'(m_arvalid), 64'(mstate == 1));
      for (int i = 0; i < N; i++) if (s_arready[i]) grant_log.push_back(i);

      ridx   = int'(m_rid[1:0]);
      exp_rv = '0;
      exp_mr = 1'b1;
      if (ridx < N) begin
        exp_rv[ridx] = m_rvalid;
        exp_mr       = s_rready[ridx];
      end
      check("s_rvalid", 64'(s_rvalid), 64'(exp_rv));
      check("m_rready", 64'(m_rready), 64'(exp_mr));
      check("err_rid", 64'(err_rid), 64'(merr));
      if (m_rvalid) begin
        for (int i = 0; i < N; i++) begin
          check("r_bcast", 64'({s_rdata[i], s_rresp[i], s_rlast[i]}),
                64'({m_rdata, m_rresp, m_rlast}));
        end
      end

      cur = {m_araddr, m_arlen, m_arsize, m_arburst, m_arid};
      if (mstate == 1) begin
        if (ar_q.size() != 0) check("ar_fields", 64'(cur), 64'(ar_q[0]));
        if (m_arready) begin
          void'(ar_q.pop_front());
          mout[mwin]++;
          mptr   = (mwin + 1) % N;
          mstate = 0;
        end
      end else if (w >= 0) begin
        ar_q.push_back({s_araddr[w], s_arlen[w], s_arsize[w], s_arburst[w], 4'(w)});
        mwin   = w;
        mstate = 1;
      end
      if (m_rvalid && ridx >= N) merr = 1'b1;
      if (m_rvalid && exp_mr && m_rlast && ridx < N) begin
        check("dec_nonzero", 64'(dut.outst_q[ridx] != 0), 64'(1));
        mout[ridx]--;
      end
    end
  end

  int exp_order [7] = '{0, 1, 2, 0, 1, 2, 0};

  initial begin
    rst_n     = 1'b0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = '0;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    m_rid     = '0;
    m_rvalid  = 1'b0;
    #1;
    check("rst_arvalid", 64'(m_arvalid), 64'(0));
    check("rst_arready", 64'(s_arready), 64'(0));
    check("rst_araddr", 64'(m_araddr), 64'(0));
    repeat (3) step();
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (10) step();

    // 2: single burst from M0, held downstream for 3 cycles
    s_araddr[0]  = 32'h1fc0_0000;
    s_arlen[0]   = 4'd7;
    s_arsize[0]  = 3'd2;
    s_arburst[0] = 2'd1;
    s_arvalid[0] = 1'b1;
    #3;
    check("t2_arready_same_cycle", 64'(s_arready), 64'(3'b001));
    step();
    s_arvalid[0] = 1'b0;
    check("t2_m_arvalid", 64'(m_arvalid), 64'(1));
    check("t2_m_arid", 64'(m_arid), 64'(0));
    check("t2_m_araddr", 64'(m_araddr), 64'(32'h1fc0_0000));
    repeat (3) step();
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    s_rready  = 3'b111;
    for (int b = 0; b < 8; b++) begin
      m_rvalid = 1'b1;
      m_rid    = '0;
      m_rdata  = $urandom;
      m_rlast  = (b == 7);
      step();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    check("t2_outst0_zero", 64'(dut.outst_q[0]), 64'(0));

    // Fresh pointer for the fairness sequence
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // 3: all masters requesting continuously
    for (int i = 0; i < N; i++) begin
      s_araddr[i]  = 32'h8000_0000 + 32'(i) * 32'h100;
      s_arlen[i]   = 4'(i + 1);
      s_arsize[i]  = 3'd2;
      s_arburst[i] = 2'd1;
    end
    m_arready = 1'b1;
    s_arvalid = 3'b111;
    repeat (12) step();
    check("t3_grants_until_full", 64'(grant_log.size()), 64'(6));
    repeat (2) step();
    m_rvalid = 1'b1;
    m_rid    = 4'd0;
    m_rlast  = 1'b1;
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    step();
    s_arvalid = '0;
    repeat (2) step();
    check("t3_grant_count", 64'(grant_log.size()), 64'(7));
    if (grant_log.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("t3_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
      end
    end

    // 4: M1 completes a burst in the same cycle its next AR is accepted
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rid     = 4'd1;
    m_rlast   = 1'b1;
    s_rready  = 3'b010;
    step();
    m_rvalid     = 1'b0;
    m_rlast      = 1'b0;
    s_araddr[1]  = 32'h9000_0040;
    s_arvalid[1] = 1'b1;
    step();
    s_arvalid[1] = 1'b0;
    check("t4_in_issue", 64'(m_arvalid), 64'(1));
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_rid     = 4'd1;
    m_rlast   = 1'b1;
    step();
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    check("t4_outst1_unchanged", 64'(dut.outst_q[1]), 64'(1));

    // 5: unmapped RID is sunk and flagged
    m_rvalid = 1'b1;
    m_rid    = 4'd7;
    m_rlast  = 1'b1;
    s_rready = '0;
    #3;
    check("t5_m_rready", 64'(m_rready), 64'(1));
    check("t5_no_rvalid", 64'(s_rvalid), 64'(0));
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    check("t5_err_set", 64'(err_rid), 64'(1));
    repeat (3) step();
    check("t5_err_sticky", 64'(err_rid), 64'(1));

    // 6: asynchronous reset while in ISSUE with three bursts outstanding
    s_rready = 3'b111;
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rid    = 4'd0;
    step();
    m_rid = 4'd2;
    step();
    m_rvalid     = 1'b0;
    m_rlast      = 1'b0;
    s_arvalid[1] = 1'b1;
    step();
    check("t6_in_issue", 64'(m_arvalid), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_arvalid", 64'(m_arvalid), 64'(0));
    check("t6_arready", 64'(s_arready), 64'(0));
    check("t6_err_rid", 64'(err_rid), 64'(0));
    check("t6_araddr", 64'(m_araddr), 64'(0));
    check("t6_arid", 64'(m_arid), 64'(0));
    for (int i = 0; i < N; i++) begin
      check($sformatf("t6_outst%0d", i), 64'(dut.outst_q[i]), 64'(0));
    end
    s_arvalid = '0;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
